// File: rtl/adf4360_hop_sequencer_pkg.sv
// Shared types and widths for the ADF4360 hop sequencer.
package adf4360_hop_sequencer_pkg;

    localparam int ADF_WORD_W = 24;
    localparam int HOP_IDX_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_ACK,
        ST_WAIT_RDY,
        ST_SETTLE
    } hop_state_t;

    // Table walk wraps to entry 0 once the final index has been used.
    function automatic logic [HOP_IDX_W-1:0] next_idx(input logic [HOP_IDX_W-1:0] idx,
                                                      input logic [HOP_IDX_W-1:0] last_idx);
        return (idx >= last_idx) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/adf4360_hop_sequencer_if.sv
// Launch/handshake bus between the hop sequencer and the ADF4360 serial programmer.
interface adf4360_hop_sequencer_if;
    import adf4360_hop_sequencer_pkg::*;

    logic                  prog_trig_o;
    logic [ADF_WORD_W-1:0] prog_R_o;
    logic [ADF_WORD_W-1:0] prog_C_o;
    logic [ADF_WORD_W-1:0] prog_N_o;
    logic                  prog_ready_i;

    modport master (
        output prog_trig_o, prog_R_o, prog_C_o, prog_N_o,
        input  prog_ready_i
    );

    modport slave (
        input  prog_trig_o, prog_R_o, prog_C_o, prog_N_o,
        output prog_ready_i
    );

endinterface

// File: rtl/adf4360_hop_sequencer_hop_table_ram.sv
// 16x24 N-word table: synchronous write, combinational read, so a same-cycle
// write and read of one entry returns the old contents.
module hop_table_ram
    import adf4360_hop_sequencer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [HOP_IDX_W-1:0]  i_wr_addr,
    input  logic [ADF_WORD_W-1:0] i_wr_data,
    input  logic [HOP_IDX_W-1:0]  i_rd_addr,
    output logic [ADF_WORD_W-1:0] o_rd_data
);

    logic [ADF_WORD_W-1:0] r_mem [0:(1<<HOP_IDX_W)-1];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/adf4360_hop_sequencer.sv
// Steps through the hop table on each strobe, launches the programmer, times
// out stalled writes and reports completion once the synthesizer has settled.
module adf4360_hop_sequencer
    import adf4360_hop_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 20000,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_en_i,
    input  logic [HOP_IDX_W-1:0]  wr_addr_i,
    input  logic [ADF_WORD_W-1:0] wr_data_i,
    input  logic [ADF_WORD_W-1:0] R_cfg_i,
    input  logic [ADF_WORD_W-1:0] C_cfg_i,
    input  logic [HOP_IDX_W-1:0]  last_idx_i,
    input  logic                  arm_i,
    input  logic                  step_i,
    adf4360_hop_sequencer_if.master prog,
    output logic [HOP_IDX_W-1:0]  idx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overrun_o,
    output logic                  err_o
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    hop_state_t            r_state, w_state_next;
    logic [HOP_IDX_W-1:0]  r_idx, w_idx_next;
    logic [ADF_WORD_W-1:0] r_prog_N, r_prog_R, r_prog_C, w_rd_data;
    logic                  r_trig, r_busy, r_done, r_overrun, r_err;
    logic                  w_overrun_next, w_err_next, w_capture;
    logic [TMO_W-1:0]      r_tmo, w_tmo_next;
    logic [SET_W-1:0]      r_settle, w_settle_next;

    hop_table_ram u_table (
        .i_clk     (clk_i),
        .i_wr_en   (wr_en_i),
        .i_wr_addr (wr_addr_i),
        .i_wr_data (wr_data_i),
        .i_rd_addr (r_idx),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_overrun_next = r_overrun;
        w_err_next     = r_err;
        w_tmo_next     = r_tmo;
        w_settle_next  = r_settle;
        w_capture      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (step_i && !arm_i) begin
                    if (prog.prog_ready_i) begin
                        w_capture    = 1'b1;
                        w_idx_next   = next_idx(r_idx, last_idx_i);
                        w_state_next = ST_LAUNCH;
                    end else begin
                        w_overrun_next = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                w_tmo_next   = '0;
                w_state_next = ST_WAIT_ACK;
            end
            // One timeout budget spans both the acknowledge and completion waits.
            ST_WAIT_ACK, ST_WAIT_RDY: begin
                w_tmo_next = r_tmo + 1'b1;
                if (r_state == ST_WAIT_RDY && prog.prog_ready_i) begin
                    w_settle_next = SET_W'(SETTLE_CYCLES - 1);
                    w_state_next  = ST_SETTLE;
                end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_err_next   = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_state == ST_WAIT_ACK && !prog.prog_ready_i) begin
                    w_state_next = ST_WAIT_RDY;
                end
            end
            ST_SETTLE: begin
                if (r_settle == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_settle_next = r_settle - 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (step_i && r_state != ST_IDLE) begin
            w_overrun_next = 1'b1;
        end
        if (arm_i) begin
            w_idx_next     = '0;
            w_overrun_next = 1'b0;
            w_err_next     = 1'b0;
        end
    end

    // Flags are computed from the next state so every output leaves a flop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_prog_N  <= '0;
            r_prog_R  <= '0;
            r_prog_C  <= '0;
            r_trig    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_err     <= 1'b0;
            r_tmo     <= '0;
            r_settle  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_trig    <= (w_state_next == ST_LAUNCH);
            r_busy    <= (w_state_next != ST_IDLE);
            r_done    <= (w_state_next == ST_SETTLE) && (w_settle_next == '0);
            r_overrun <= w_overrun_next;
            r_err     <= w_err_next;
            r_tmo     <= w_tmo_next;
            r_settle  <= w_settle_next;
            if (w_capture) begin
                r_prog_N <= w_rd_data;
                r_prog_R <= R_cfg_i;
                r_prog_C <= C_cfg_i;
            end
        end
    end

    assign prog.prog_trig_o = r_trig;
    assign prog.prog_N_o    = r_prog_N;
    assign prog.prog_R_o    = r_prog_R;
    assign prog.prog_C_o    = r_prog_C;
    assign idx_o            = r_idx;
    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign overrun_o        = r_overrun;
    assign err_o            = r_err;

endmodule

// File: tb/tb_adf4360_hop_sequencer.sv
// Self-checking bench for adf4360_hop_sequencer with a behavioural programmer
// and a launch scoreboard keyed on prog_trig_o.
module tb_adf4360_hop_sequencer;

    localparam int SETTLE  = 50;
    localparam int TIMEOUT = 4096;
    localparam int PROG_BUSY = 75;

    typedef struct {
        logic [23:0] n;
        logic [23:0] r;
        logic [23:0] c;
    } launch_t;

    typedef struct {
        logic [3:0]  lastIdx;
        bit          doArm;
        logic [23:0] expN;
        logic [3:0]  expIdxAfter;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        wrEn;
    logic [3:0]  wrAddr;
    logic [23:0] wrData;
    logic [23:0] rCfg;
    logic [23:0] cCfg;
    logic [3:0]  lastIdx;
    logic        arm;
    logic        step;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        err;

    adf4360_hop_sequencer_if progBus ();

    adf4360_hop_sequencer #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .wr_en_i    (wrEn),
        .wr_addr_i  (wrAddr),
        .wr_data_i  (wrData),
        .R_cfg_i    (rCfg),
        .C_cfg_i    (cCfg),
        .last_idx_i (lastIdx),
        .arm_i      (arm),
        .step_i     (step),
        .prog       (progBus),
        .idx_o      (idx),
        .busy_o     (busy),
        .done_o     (done),
        .overrun_o  (overrun),
        .err_o      (err)
    );

    int total = 0;
    int bad = 0;
    int cycle = 0;
    int trigCount = 0;
    int doneCount = 0;
    int riseCycle = 0;
    bit riseSeen = 0;
    bit progAckEnable = 1;
    int progCnt = 0;
    logic prevReady = 1'b1;
    logic prevBusy = 1'b0;
    logic [23:0] prevN, prevR, prevC;
    launch_t expQ[$];
    launch_t monExp;
    logic [23:0] tableModel [16];
    logic [3:0]  expIdx;
    vec_t vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural programmer: drops ready for PROG_BUSY cycles after a trigger.
    always @(posedge clk) begin
        if (progBus.prog_trig_o && progAckEnable) begin
            progCnt <= PROG_BUSY;
        end else if (progCnt > 0) begin
            progCnt <= progCnt - 1;
        end
    end
    assign progBus.prog_ready_i = (progCnt == 0);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Call on a falling edge; drives one cycle of host activity.
    task automatic applyStimulus(input bit doWr, input logic [3:0] addr, input logic [23:0] data,
                                 input bit doArm, input bit doStep);
        wrEn   = doWr;
        wrAddr = addr;
        wrData = data;
        arm    = doArm;
        step   = doStep;
        @(negedge clk);
        wrEn = 1'b0;
        arm  = 1'b0;
        step = 1'b0;
    endtask

    task automatic launchHop();
        expQ.push_back('{tableModel[expIdx], rCfg, cCfg});
        expIdx = (expIdx >= lastIdx) ? 4'd0 : expIdx + 4'd1;
        applyStimulus(1'b0, 4'd0, 24'd0, 1'b0, 1'b1);
        checkOutput("trigAfterStep", 32'(progBus.prog_trig_o), 1);
        checkOutput("busyAfterStep", 32'(busy), 1);
    endtask

    task automatic waitDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(seen), 1);
        @(negedge clk);
        checkOutput("busyAfterDone", 32'(busy), 0);
    endtask

    // Scoreboard and timing monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cycle++;
        if (rst_n) begin
            if (progBus.prog_ready_i && !prevReady) begin
                riseCycle = cycle;
                riseSeen  = 1'b1;
            end
            if (progBus.prog_trig_o) begin
                trigCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedTrig", 1, 0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("progN", 32'(progBus.prog_N_o), 32'(monExp.n));
                    checkOutput("progR", 32'(progBus.prog_R_o), 32'(monExp.r));
                    checkOutput("progC", 32'(progBus.prog_C_o), 32'(monExp.c));
                end
            end
            if (done) begin
                doneCount++;
                checkOutput("doneAfterRise", 32'(riseSeen), 1);
                checkOutput("settleLatency", 32'(cycle - riseCycle), SETTLE);
                riseSeen = 1'b0;
            end
            if (busy && prevBusy) begin
                checkOutput("wordsStable",
                            32'(progBus.prog_N_o == prevN && progBus.prog_R_o == prevR &&
                                progBus.prog_C_o == prevC), 1);
            end
        end
        prevReady = progBus.prog_ready_i;
        prevBusy  = busy;
        prevN     = progBus.prog_N_o;
        prevR     = progBus.prog_R_o;
        prevC     = progBus.prog_C_o;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int trigBefore;
        int doneBefore;
        bit seen;

        vecs[0] = '{4'd2, 1'b1, 24'h000101, 4'd1};
        vecs[1] = '{4'd2, 1'b0, 24'h000202, 4'd2};
        vecs[2] = '{4'd2, 1'b0, 24'h000303, 4'd0};
        vecs[3] = '{4'd2, 1'b0, 24'h000101, 4'd1};
        vecs[4] = '{4'd0, 1'b1, 24'h000101, 4'd0};
        vecs[5] = '{4'd0, 1'b0, 24'h000101, 4'd0};

        for (int i = 0; i < 16; i++) tableModel[i] = 24'd0;
        expIdx  = 4'd0;
        rst_n   = 1'b0;
        wrEn    = 1'b0;
        wrAddr  = 4'd0;
        wrData  = 24'd0;
        rCfg    = 24'h5A0000;
        cCfg    = 24'h3C0000;
        lastIdx = 4'd2;
        arm     = 1'b0;
        step    = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rstIdx", 32'(idx), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstTrig", 32'(progBus.prog_trig_o), 0);
        checkOutput("rstDone", 32'(done), 0);
        checkOutput("rstOverrun", 32'(overrun), 0);
        checkOutput("rstErr", 32'(err), 0);
        checkOutput("rstN", 32'(progBus.prog_N_o), 0);
        checkOutput("rstR", 32'(progBus.prog_R_o), 0);
        checkOutput("rstC", 32'(progBus.prog_C_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            tableModel[i] = 24'h000101 * (i + 1);
            applyStimulus(1'b1, 4'(i), tableModel[i], 1'b0, 1'b0);
        end

        $display("[TB] table-driven hop sequence");
        for (int i = 0; i < 6; i++) begin
            lastIdx = vecs[i].lastIdx;
            rCfg    = 24'h100000 + 24'(i);
            cCfg    = 24'h200000 + 24'(i);
            if (vecs[i].doArm) begin
                applyStimulus(1'b0, 4'd0, 24'd0, 1'b1, 1'b0);
                checkOutput("armIdx", 32'(idx), 0);
            end
            expQ.push_back('{vecs[i].expN, rCfg, cCfg});
            applyStimulus(1'b0, 4'd0, 24'd0, 1'b0, 1'b1);
            checkOutput("vecTrig", 32'(progBus.prog_trig_o), 1);
            checkOutput("vecBusy", 32'(busy), 1);
            waitDone("vecDone");
            checkOutput("vecIdx", 32'(idx), 32'(vecs[i].expIdxAfter));
        end
        checkOutput("vecDoneCount", 32'(doneCount), 6);
        expIdx = 4'd0;

        $display("[TB] overrun while busy");
        lastIdx = 4'd2;
        trigBefore = trigCount;
        launchHop();
        repeat (10) @(negedge clk);
        applyStimulus(1'b0, 4'd0, 24'd0, 1'b0, 1'b1);
        checkOutput("overrunSet", 32'(overrun), 1);
        checkOutput("overrunIdx", 32'(idx), 1);
        waitDone("overrunDone");
        checkOutput("overrunTrigCount", 32'(trigCount - trigBefore), 1);
        checkOutput("overrunSticky", 32'(overrun), 1);
        applyStimulus(1'b0, 4'd0, 24'd0, 1'b1, 1'b0);
        expIdx = 4'd0;
        checkOutput("armClearsOverrun", 32'(overrun), 0);
        checkOutput("armIdx0", 32'(idx), 0);

        $display("[TB] programmer timeout");
        progAckEnable = 1'b0;
        doneBefore = doneCount;
        launchHop();
        repeat (4000) @(negedge clk);
        checkOutput("errEarly", 32'(err), 0);
        checkOutput("busyBeforeTimeout", 32'(busy), 1);
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("errSet", 32'(seen), 1);
        checkOutput("busyAfterTimeout", 32'(busy), 0);
        repeat (2) @(negedge clk);
        checkOutput("noDoneOnTimeout", 32'(doneCount - doneBefore), 0);
        progAckEnable = 1'b1;
        applyStimulus(1'b0, 4'd0, 24'd0, 1'b1, 1'b0);
        expIdx = 4'd0;
        checkOutput("armClearsErr", 32'(err), 0);

        $display("[TB] table write colliding with launch");
        launchHop();
        waitDone("collideFirstDone");
        expQ.push_back('{tableModel[1], rCfg, cCfg});
        tableModel[1] = 24'h0ABCDE;
        expIdx = 4'd2;
        applyStimulus(1'b1, 4'd1, 24'h0ABCDE, 1'b0, 1'b1);
        checkOutput("collideTrig", 32'(progBus.prog_trig_o), 1);
        waitDone("collideDone");
        for (int i = 0; i < 3; i++) begin
            launchHop();
            waitDone("revisitDone");
        end
        checkOutput("revisitIdx", 32'(idx), 2);

        $display("[TB] reset during settle");
        launchHop();
        repeat (100) @(negedge clk);
        checkOutput("busyInSettle", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstIdx", 32'(idx), 0);
        checkOutput("midRstBusy", 32'(busy), 0);
        checkOutput("midRstDone", 32'(done), 0);
        checkOutput("midRstTrig", 32'(progBus.prog_trig_o), 0);
        checkOutput("midRstN", 32'(progBus.prog_N_o), 0);
        checkOutput("midRstR", 32'(progBus.prog_R_o), 0);
        checkOutput("midRstC", 32'(progBus.prog_C_o), 0);
        riseSeen = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expIdx = 4'd0;
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 24'd0, 1'b1, 1'b0);
        launchHop();
        waitDone("postRstDone");
        checkOutput("postRstIdx", 32'(idx), 1);

        $display("[TB] arm and step together");
        launchHop();
        repeat (5) @(negedge clk);
        applyStimulus(1'b0, 4'd0, 24'd0, 1'b0, 1'b1);
        waitDone("preArmDone");
        checkOutput("preArmOverrun", 32'(overrun), 1);
        checkOutput("preArmIdx", 32'(idx), 2);
        trigBefore = trigCount;
        applyStimulus(1'b0, 4'd0, 24'd0, 1'b1, 1'b1);
        expIdx = 4'd0;
        checkOutput("armStepTrig", 32'(progBus.prog_trig_o), 0);
        checkOutput("armStepIdx", 32'(idx), 0);
        checkOutput("armStepOverrun", 32'(overrun), 0);
        checkOutput("armStepErr", 32'(err), 0);
        repeat (3) @(negedge clk);
        checkOutput("armStepBusy", 32'(busy), 0);
        checkOutput("armStepNoTrig", 32'(trigCount - trigBefore), 0);

        checkOutput("scoreboardEmpty", 32'(expQ.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
